// File: rtl/reg_file_cc.sv
// reg_file_cc: LC-3 style register file with NZP condition codes and branch enable.
// Optional write-through forwarding on the read ports when REG_FILE_BYPASS_EN is defined.
module reg_file_cc #(
  parameter  int WIDTH = 16,
  parameter  int NREGS = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Din,
  input  logic             LD_REG,
  input  logic [AW-1:0]    DR,
  input  logic [AW-1:0]    SR1,
  input  logic [AW-1:0]    SR2,
  output logic [WIDTH-1:0] SR1_OUT,
  output logic [WIDTH-1:0] SR2_OUT,
  input  logic             LD_CC,
  input  logic [WIDTH-1:0] CC_In,
  output logic [2:0]       NZP,
  input  logic             LD_BEN,
  input  logic [2:0]       IR_NZP,
  output logic             BEN
);

  logic [WIDTH-1:0] regs [NREGS];
  logic [2:0]       nzp_q;
  logic             ben_q;
  logic             dr_valid;

  // A destination outside the populated range silently drops the write.
  assign dr_valid = (32'(DR) < NREGS);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (LD_REG && dr_valid) begin
      regs[DR] <= Din;
    end
  end

  // BEN samples the flags before this edge, so a same-edge CC load is not seen.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      nzp_q <= 3'b000;
      ben_q <= 1'b0;
    end else begin
      if (LD_CC) begin
        nzp_q <= {CC_In[WIDTH-1], CC_In == '0, !CC_In[WIDTH-1] && (CC_In != '0)};
      end
      if (LD_BEN) begin
        ben_q <= |(IR_NZP & nzp_q);
      end
    end
  end

  always_comb begin
    SR1_OUT = '0;
    if (32'(SR1) < NREGS) SR1_OUT = regs[SR1];
`ifdef REG_FILE_BYPASS_EN
    if (!Reset && LD_REG && dr_valid && (SR1 == DR)) SR1_OUT = Din;
`endif
  end

  always_comb begin
    SR2_OUT = '0;
    if (32'(SR2) < NREGS) SR2_OUT = regs[SR2];
`ifdef REG_FILE_BYPASS_EN
    if (!Reset && LD_REG && dr_valid && (SR2 == DR)) SR2_OUT = Din;
`endif
  end

  assign NZP = nzp_q;
  assign BEN = ben_q;

endmodule

// File: tb/tb_reg_file_cc.sv
// Bench for reg_file_cc: two instances (NREGS=8 and NREGS=6) share all inputs and are
// checked every cycle against an array/arithmetic model, plus literal expectations.
module tb_reg_file_cc;

  logic        clk;
  logic        Reset;
  logic [15:0] din;
  logic        ld_reg;
  logic [2:0]  dr;
  logic [2:0]  sr1;
  logic [2:0]  sr2;
  logic        ld_cc;
  logic [15:0] cc_in;
  logic        ld_ben;
  logic [2:0]  ir_nzp;

  logic [15:0] sr1_out8, sr2_out8, sr1_out6, sr2_out6;
  logic [2:0]  nzp8, nzp6;
  logic        ben8, ben6;

  int errors = 0;
  int checks = 0;

  logic [15:0] m8 [8];
  logic [15:0] m6 [6];
  logic [2:0]  m_nzp;
  logic        m_ben;

  reg_file_cc #(.WIDTH(16), .NREGS(8)) dut8 (
    .clk(clk), .Reset(Reset), .Din(din), .LD_REG(ld_reg), .DR(dr),
    .SR1(sr1), .SR2(sr2), .SR1_OUT(sr1_out8), .SR2_OUT(sr2_out8),
    .LD_CC(ld_cc), .CC_In(cc_in), .NZP(nzp8), .LD_BEN(ld_ben),
    .IR_NZP(ir_nzp), .BEN(ben8)
  );

  reg_file_cc #(.WIDTH(16), .NREGS(6)) dut6 (
    .clk(clk), .Reset(Reset), .Din(din), .LD_REG(ld_reg), .DR(dr),
    .SR1(sr1), .SR2(sr2), .SR1_OUT(sr1_out6), .SR2_OUT(sr2_out6),
    .LD_CC(ld_cc), .CC_In(cc_in), .NZP(nzp6), .LD_BEN(ld_ben),
    .IR_NZP(ir_nzp), .BEN(ben6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] expFlags(input logic [15:0] v);
    shortint s;
    s = v;
    if (s < 0) return 3'b100;
    if (s == 0) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [15:0] expRead(input int n, input logic [2:0] sel);
    if (int'(sel) >= n) return 16'h0000;
`ifdef REG_FILE_BYPASS_EN
    if (!Reset && ld_reg && sel == dr) return din;
`endif
    if (n == 8) return m8[sel];
    return m6[sel];
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 8; i++) m8[i] = 16'h0000;
    for (int i = 0; i < 6; i++) m6[i] = 16'h0000;
    m_nzp = 3'b000;
    m_ben = 1'b0;
  endtask

  // One clocked operation: drive, take the edge, advance the model, drop strobes.
  task automatic applyStimulus(input logic l_reg, input logic [2:0] d, input logic [15:0] data,
                               input logic l_cc, input logic [15:0] cc,
                               input logic l_ben, input logic [2:0] ir,
                               input logic [2:0] s1, input logic [2:0] s2);
    ld_reg = l_reg; dr = d; din = data;
    ld_cc = l_cc; cc_in = cc; ld_ben = l_ben; ir_nzp = ir;
    sr1 = s1; sr2 = s2;
    @(posedge clk);
    if (l_ben) m_ben = (ir & m_nzp) != 3'b000;
    if (l_cc) m_nzp = expFlags(cc);
    if (l_reg) begin
      m8[d] = data;
      if (int'(d) < 6) m6[d] = data;
    end
    #1;
    ld_reg = 1'b0; ld_cc = 1'b0; ld_ben = 1'b0;
  endtask

  always @(negedge clk) begin
    checkOutput("sr1_out8", 32'(sr1_out8), 32'(expRead(8, sr1)));
    checkOutput("sr2_out8", 32'(sr2_out8), 32'(expRead(8, sr2)));
    checkOutput("sr1_out6", 32'(sr1_out6), 32'(expRead(6, sr1)));
    checkOutput("sr2_out6", 32'(sr2_out6), 32'(expRead(6, sr2)));
    checkOutput("nzp8", 32'(nzp8), 32'(m_nzp));
    checkOutput("nzp6", 32'(nzp6), 32'(m_nzp));
    checkOutput("ben8", 32'(ben8), 32'(m_ben));
    checkOutput("ben6", 32'(ben6), 32'(m_ben));
  end

  initial begin
    Reset = 1'b1; din = '0; ld_reg = 0; dr = 0; sr1 = 0; sr2 = 0;
    ld_cc = 0; cc_in = '0; ld_ben = 0; ir_nzp = '0;
    clearModel();
    #2;
    checkOutput("reset_sr1", 32'(sr1_out8), 32'h0);
    checkOutput("reset_nzp", 32'(nzp8), 32'h0);
    checkOutput("reset_ben", 32'(ben8), 32'h0);
    @(posedge clk); #1 Reset = 1'b0;

    // Mid-run asynchronous reset
    applyStimulus(1, 3'd3, 16'h1234, 0, 16'h0, 0, 3'b000, 3'd3, 3'd0);
    applyStimulus(0, 3'd0, 16'h0, 1, 16'h8000, 0, 3'b000, 3'd3, 3'd0);
    checkOutput("pre_reset_r3", 32'(sr1_out8), 32'h1234);
    checkOutput("pre_reset_nzp", 32'(nzp8), 32'h4);
    #2 Reset = 1'b1;
    clearModel();
    #1;
    checkOutput("async_reset_r3", 32'(sr1_out8), 32'h0);
    checkOutput("async_reset_nzp", 32'(nzp8), 32'h0);
    checkOutput("async_reset_ben", 32'(ben8), 32'h0);
    @(posedge clk); #1 Reset = 1'b0;

    // Write all registers, then sweep both read ports
    for (int i = 0; i < 8; i++)
      applyStimulus(1, 3'(i), 16'hA000 + 16'(i), 0, 16'h0, 0, 3'b000, 3'd0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i); sr2 = 3'(7 - i);
      @(posedge clk); #1;
    end
    sr1 = 3'd5; sr2 = 3'd5; #1;
    checkOutput("same_sel_sr1", 32'(sr1_out8), 32'hA005);
    checkOutput("same_sel_sr2", 32'(sr2_out8), 32'hA005);
    sr1 = 3'd7; #1;
    checkOutput("n6_out_of_range_read", 32'(sr1_out6), 32'h0);

    // Flag derivation
    applyStimulus(0, 3'd0, 16'h0, 1, 16'hFFFF, 0, 3'b000, 3'd1, 3'd2);
    checkOutput("nzp_neg", 32'(nzp8), 32'h4);
    applyStimulus(0, 3'd0, 16'h0, 1, 16'h0000, 0, 3'b000, 3'd1, 3'd2);
    checkOutput("nzp_zero", 32'(nzp8), 32'h2);
    applyStimulus(0, 3'd0, 16'h0, 1, 16'h0001, 0, 3'b000, 3'd1, 3'd2);
    checkOutput("nzp_pos", 32'(nzp8), 32'h1);

    // BEN uses the flags from before a same-edge CC load
    applyStimulus(0, 3'd0, 16'h0, 1, 16'h0000, 0, 3'b000, 3'd1, 3'd2);
    applyStimulus(0, 3'd0, 16'h0, 1, 16'h0005, 1, 3'b010, 3'd1, 3'd2);
    checkOutput("ben_old_nzp", 32'(ben8), 32'h1);
    checkOutput("nzp_after_ben", 32'(nzp8), 32'h1);
    applyStimulus(0, 3'd0, 16'h0, 0, 16'h0, 1, 3'b010, 3'd1, 3'd2);
    checkOutput("ben_cleared", 32'(ben8), 32'h0);

    // Same-cycle write to a register being read
    ld_reg = 1; dr = 3'd2; din = 16'hBEEF; sr1 = 3'd2; sr2 = 3'd3; #1;
`ifdef REG_FILE_BYPASS_EN
    checkOutput("bypass_pre_edge", 32'(sr1_out8), 32'hBEEF);
`else
    checkOutput("no_bypass_pre_edge", 32'(sr1_out8), 32'hA002);
`endif
    applyStimulus(1, 3'd2, 16'hBEEF, 0, 16'h0, 0, 3'b000, 3'd2, 3'd3);
    checkOutput("post_edge_r2", 32'(sr1_out8), 32'hBEEF);

    // Out-of-range destination on the 6-register instance
    applyStimulus(1, 3'd7, 16'h5555, 0, 16'h0, 0, 3'b000, 3'd7, 3'd5);
    checkOutput("n6_drop_read", 32'(sr1_out6), 32'h0);
    checkOutput("n6_r5_intact", 32'(sr2_out6), 32'hA005);
    checkOutput("n8_r7_written", 32'(sr1_out8), 32'h5555);

    // All three strobes together
    applyStimulus(1, 3'd1, 16'h8001, 1, 16'h8001, 1, 3'b001, 3'd1, 3'd0);
    checkOutput("all_strobes_r1", 32'(sr1_out8), 32'h8001);
    checkOutput("all_strobes_nzp", 32'(nzp8), 32'h4);
    checkOutput("all_strobes_ben", 32'(ben8), 32'h1);

    // Idle edges: everything holds
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hold_nzp", 32'(nzp8), 32'h4);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
